// File: rtl/seq_magnitude_comparator.sv
//------------------------------------------------------------------------------
// Module  : seq_magnitude_comparator
// Brief   : Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock,
//           unsigned or two's-complement compare with optional early exit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter int CHUNK      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             a_less_b,
  output logic             a_greater_b
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;
  logic               gt_q, gt_d;
  logic               plt_q, plt_d;
  logic               pgt_q, pgt_d;

  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic               chunk_neq;
  logic               run_lt;
  logic               run_gt;
  logic               finish;

  // Operands shift left each step, so the chunk under test is always the top one.
  assign a_chunk   = a_q[WIDTH-1 -: CHUNK];
  assign b_chunk   = b_q[WIDTH-1 -: CHUNK];
  assign chunk_neq = (a_chunk != b_chunk);

  // Without early exit the first unequal chunk still decides; later chunks cannot override it.
  assign run_lt = plt_q | (~pgt_q & (a_chunk < b_chunk));
  assign run_gt = pgt_q | (~plt_q & (a_chunk > b_chunk));
  assign finish = (chunk_neq && (EARLY_EXIT != 0)) || (idx_q == '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    plt_d   = plt_q;
    pgt_d   = pgt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Flipping the sign bit maps two's complement onto offset binary.
          a_d            = A;
          b_d            = B;
          a_d[WIDTH-1]   = A[WIDTH-1] ^ signed_mode;
          b_d[WIDTH-1]   = B[WIDTH-1] ^ signed_mode;
          idx_d          = IDX_W'(NCHUNK - 1);
          plt_d          = 1'b0;
          pgt_d          = 1'b0;
          busy_d         = 1'b1;
          state_d        = S_RUN;
        end
      end
      S_RUN: begin
        if (finish) begin
          lt_d    = run_lt;
          gt_d    = run_gt;
          eq_d    = ~(run_lt | run_gt);
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
          a_d   = a_q << CHUNK;
          b_d   = b_q << CHUNK;
          plt_d = run_lt;
          pgt_d = run_gt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      plt_q   <= 1'b0;
      pgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      plt_q   <= plt_d;
      pgt_q   <= pgt_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign eq          = eq_q;
  assign a_less_b    = lt_q;
  assign a_greater_b = gt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_magnitude_comparator.sv
//------------------------------------------------------------------------------
// Module  : tb_seq_magnitude_comparator
// Brief   : Several comparator configurations against a behavioural model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_magnitude_comparator;

  localparam int NC = 5;
  localparam int CFG_W [NC] = '{8, 8, 16, 8, 6};
  localparam int CFG_C [NC] = '{2, 2, 4, 8, 1};
  localparam int CFG_E [NC] = '{1, 0, 1, 1, 1};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] start_v = '0;
  logic [NC-1:0] sm_v = '0;
  logic [15:0]   A_s [NC];
  logic [15:0]   B_s [NC];
  logic [NC-1:0] busy_v, done_v, eq_v, lt_v, gt_v;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state
  bit m_busy [NC];
  bit m_done [NC];
  bit m_eq [NC];
  bit m_lt [NC];
  bit m_gt [NC];
  bit m_has [NC];
  int m_rem [NC];
  int m_rel [NC];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NC; k++) begin : g_dut
    localparam int W = CFG_W[k];
    seq_magnitude_comparator #(
      .WIDTH(W), .CHUNK(CFG_C[k]), .EARLY_EXIT(CFG_E[k])
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_v[k]), .signed_mode(sm_v[k]),
      .A(A_s[k][W-1:0]), .B(B_s[k][W-1:0]),
      .busy(busy_v[k]), .done(done_v[k]), .eq(eq_v[k]),
      .a_less_b(lt_v[k]), .a_greater_b(gt_v[k])
    );
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // Result as a signed-integer relation and latency from the first differing chunk.
  function automatic void model_calc(input int w, input int c, input int e,
                                     input logic [15:0] a, input logic [15:0] b,
                                     input logic sm, output int j, output int rel);
    int n, ua, ub, va, vb, cm, sh;
    bit found;
    n  = w / c;
    ua = int'(a) & ((1 << w) - 1);
    ub = int'(b) & ((1 << w) - 1);
    va = ua;
    vb = ub;
    if (sm) begin
      if (va >= (1 << (w - 1))) va -= (1 << w);
      if (vb >= (1 << (w - 1))) vb -= (1 << w);
    end
    rel = (va < vb) ? -1 : ((va > vb) ? 1 : 0);
    j = n;
    found = 1'b0;
    cm = (1 << c) - 1;
    if (e != 0) begin
      for (int i = 0; i < n; i++) begin
        sh = w - (i + 1) * c;
        if (!found && ((((ua ^ ub) >> sh) & cm) != 0)) begin
          j = i + 1;
          found = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic [2:0] rel_vec(input int rel);
    return (rel == 0) ? 3'b100 : ((rel < 0) ? 3'b010 : 3'b001);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) begin
      int tj, tr;
      m_done[k] = 1'b0;
      if (rst) begin
        m_busy[k] = 1'b0;
        m_eq[k] = 1'b0; m_lt[k] = 1'b0; m_gt[k] = 1'b0;
        m_has[k] = 1'b0;
      end else if (m_busy[k]) begin
        m_rem[k] = m_rem[k] - 1;
        if (m_rem[k] == 0) begin
          m_busy[k] = 1'b0;
          m_done[k] = 1'b1;
          m_has[k]  = 1'b1;
          m_eq[k] = (m_rel[k] == 0);
          m_lt[k] = (m_rel[k] < 0);
          m_gt[k] = (m_rel[k] > 0);
        end
      end else if (start_v[k]) begin
        model_calc(CFG_W[k], CFG_C[k], CFG_E[k], A_s[k], B_s[k], sm_v[k], tj, tr);
        m_rem[k]  = tj;
        m_rel[k]  = tr;
        m_busy[k] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("cfg%0d_outs", k),
            32'({busy_v[k], done_v[k], eq_v[k], lt_v[k], gt_v[k]}),
            32'({m_busy[k], m_done[k], m_eq[k], m_lt[k], m_gt[k]}));
        if (m_has[k])
          chk($sformatf("cfg%0d_onehot", k), 32'($onehot({eq_v[k], lt_v[k], gt_v[k]})), 32'd1);
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen (cnt = edges after start).
  task automatic go(input int k, input logic [15:0] a, input logic [15:0] b,
                    input logic sm, output int cnt);
    start_v[k] = 1'b1; A_s[k] = a; B_s[k] = b; sm_v[k] = sm;
    @(negedge clk);
    start_v[k] = 1'b0;
    A_s[k] = 16'($urandom); B_s[k] = 16'($urandom); sm_v[k] = 1'($urandom);
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (done_v[k]) break;
    end
    if (!done_v[k]) begin
      total++; bad++;
      $display("FAIL cfg%0d_timeout got=no_done want=done", k);
    end
  endtask

  task automatic directed(input int k, input logic [15:0] a, input logic [15:0] b,
                          input logic sm, input int ej, input int er);
    int mj, mr, cnt;
    model_calc(CFG_W[k], CFG_C[k], CFG_E[k], a, b, sm, mj, mr);
    chk($sformatf("model_lat_cfg%0d_%0h_%0h", k, a, b), 32'(mj), 32'(ej));
    chk($sformatf("model_rel_cfg%0d_%0h_%0h", k, a, b), 32'(mr), 32'(er));
    go(k, a, b, sm, cnt);
    chk($sformatf("lat_cfg%0d_%0h_%0h", k, a, b), 32'(cnt), 32'(ej));
    chk($sformatf("res_cfg%0d_%0h_%0h", k, a, b),
        32'({eq_v[k], lt_v[k], gt_v[k]}), 32'(rel_vec(er)));
  endtask

  task automatic rand_txn(input int k);
    logic [15:0] a, b;
    logic sm;
    int ej, er, cnt;
    a = 16'($urandom);
    case ($urandom_range(0, 3))
      0: b = a;
      1: b = a ^ (16'd1 << $urandom_range(0, CFG_W[k] - 1));
      default: b = 16'($urandom);
    endcase
    sm = 1'($urandom);
    model_calc(CFG_W[k], CFG_C[k], CFG_E[k], a, b, sm, ej, er);
    go(k, a, b, sm, cnt);
    chk($sformatf("rand_lat_cfg%0d", k), 32'(cnt), 32'(ej));
  endtask

  initial begin
    int cnt;
    for (int k = 0; k < NC; k++) begin A_s[k] = '0; B_s[k] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_outs", 32'({busy_v, done_v, eq_v, lt_v, gt_v}), 32'd0);
    @(negedge clk);

    directed(0, 16'h5A, 16'h5A, 1'b0, 4, 0);
    directed(0, 16'h80, 16'h7F, 1'b0, 1, 1);
    directed(0, 16'h80, 16'h7F, 1'b1, 1, -1);
    directed(0, 16'hFF, 16'h01, 1'b1, 1, -1);
    directed(0, 16'h03, 16'h02, 1'b0, 4, 1);
    repeat (3) @(negedge clk);
    chk("hold_idle", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b001);

    directed(1, 16'h5A, 16'h5A, 1'b0, 4, 0);
    directed(1, 16'h80, 16'h7F, 1'b0, 4, 1);
    directed(1, 16'h80, 16'h7F, 1'b1, 4, -1);
    directed(1, 16'hFF, 16'h01, 1'b1, 4, -1);
    directed(1, 16'h03, 16'h02, 1'b0, 4, 1);
    directed(2, 16'h1234, 16'h1235, 1'b0, 4, -1);
    directed(3, 16'h5A, 16'h5A, 1'b0, 1, 0);
    directed(4, 16'h20, 16'h00, 1'b1, 1, -1);
    directed(4, 16'h01, 16'h00, 1'b0, 6, 1);

    // start re-asserted while busy with other operands must be ignored
    @(negedge clk);
    start_v[0] = 1'b1; A_s[0] = 16'h5A; B_s[0] = 16'h5A; sm_v[0] = 1'b0;
    @(negedge clk);
    A_s[0] = 16'h00; B_s[0] = 16'hFF;
    @(negedge clk);
    A_s[0] = 16'hFF; B_s[0] = 16'h00;
    @(negedge clk);
    start_v[0] = 1'b0;
    cnt = 2;
    while (cnt < 40 && !done_v[0]) begin @(negedge clk); cnt++; end
    chk("ignore_lat", 32'(cnt), 32'd4);
    chk("ignore_res", 32'({eq_v[0], lt_v[0], gt_v[0]}), 32'b100);
    // accepted in the done cycle
    directed(0, 16'h80, 16'h7F, 1'b0, 1, 1);

    // reset mid-compare aborts
    @(negedge clk);
    start_v[0] = 1'b1; A_s[0] = 16'h5A; B_s[0] = 16'h5A; sm_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_abort", 32'({busy_v[0], done_v[0], eq_v[0], lt_v[0], gt_v[0]}), 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_nodone", 32'(done_v[0]), 32'd0);
    directed(0, 16'h03, 16'h02, 1'b0, 4, 1);

    for (int k = 0; k < NC; k++)
      for (int n = 0; n < 2000; n++) rand_txn(k);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
